// File: rtl/sobel_axil_regs_if.sv
// -----------------------------------------------------------------------------
// sobel_axil_regs_if
// AXI4-Lite bus bundle between the sobel_filter control master (or its BFM)
// and the sobel_axil_regs register file.
//
// Signals (AXI4-Lite channel names, lower case):
//   AW : awaddr, awprot, awvalid, awready
//   W  : wdata, wstrb, wvalid, wready
//   B  : bresp, bvalid, bready
//   AR : araddr, arprot, arvalid, arready
//   R  : rdata, rresp, rvalid, rready
// Modports:
//   master : drives addresses, write data, strobes, VALIDs on AW/W/AR, B/R READYs
//   slave  : drives AW/W/AR READYs, B/R responses and VALIDs, read data
// -----------------------------------------------------------------------------
interface sobel_axil_regs_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
);

   logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]                      awprot;
   logic                            awvalid;
   logic                            awready;

   logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                            wvalid;
   logic                            wready;

   logic [1:0]                      bresp;
   logic                            bvalid;
   logic                            bready;

   logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
   logic [2:0]                      arprot;
   logic                            arvalid;
   logic                            arready;

   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                      rresp;
   logic                            rvalid;
   logic                            rready;

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );

endinterface

// File: rtl/sobel_axil_regs.sv
// -----------------------------------------------------------------------------
// sobel_axil_regs
// AXI4-Lite slave holding four 32-bit read/write control registers for the
// sobel_filter datapath. AW and W are collected independently, B and R
// back-pressure is honoured, and every committed write with a non-zero strobe
// raises a one-cycle pulse for the addressed register.
//
// Ports:
//   S_AXI_ACLK     in   clock
//   S_AXI_ARESETN  in   synchronous active-low reset
//   axi            if   AXI4-Lite slave modport (see sobel_axil_regs_if)
//   reg0_out..3    out  current register contents, straight from flops
//   reg_wr_pulse   out  bit n high for the cycle register n is committed
// -----------------------------------------------------------------------------
module sobel_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   sobel_axil_regs_if.slave              axi,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_out,
   output logic [3:0]                    reg_wr_pulse
);

   localparam int NUM_REGS = 4;
   localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
   localparam int IDX_LSB  = 2;   // byte address -> word index

   typedef enum logic [1:0] {
      W_COLLECT,
      W_COMMIT,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_t;

   w_state_t                      w_state;
   r_state_t                      r_state;

   logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

   // Held write address / data while the other channel is still outstanding
   logic                          aw_held;
   logic                          w_held;
   logic [1:0]                    aw_idx_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]             wstrb_q;

   logic                          aw_hs;
   logic                          w_hs;
   logic                          aw_held_next;
   logic                          w_held_next;
   logic [1:0]                    aw_idx_next;
   logic [STRB_W-1:0]             wstrb_next;
   logic [3:0]                    pulse_next;

   // Handshakes only happen in W_COLLECT because the READYs are low elsewhere
   assign aw_hs        = axi.awvalid & axi.awready;
   assign w_hs         = axi.wvalid & axi.wready;
   assign aw_held_next = aw_held | aw_hs;
   assign w_held_next  = w_held | w_hs;
   assign aw_idx_next  = aw_hs ? axi.awaddr[IDX_LSB +: 2] : aw_idx_q;
   assign wstrb_next   = w_hs ? axi.wstrb : wstrb_q;

   // Pulse pattern for the write about to enter W_COMMIT; registered so it is
   // high exactly during the commit cycle.
   always_comb begin
      // NOTE: default assignment first so every path drives pulse_next and no latch is inferred.
      pulse_next = '0;
      if (wstrb_next != '0) begin
         pulse_next[aw_idx_next] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Write path
   // ---------------------------------------------------------------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         w_state      <= W_COLLECT;
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_idx_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         axi.awready  <= 1'b0;
         axi.wready   <= 1'b0;
         axi.bvalid   <= 1'b0;
         reg_wr_pulse <= '0;
         // NOTE: the register file is four flop words, not a RAM, so it is cleared on reset.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         // NOTE: all state here uses non-blocking assignments so concurrent readers see pre-edge values.
         case (w_state)
            W_COLLECT: begin
               if (aw_hs) begin
                  aw_held  <= 1'b1;
                  aw_idx_q <= axi.awaddr[IDX_LSB +: 2];
               end
               if (w_hs) begin
                  w_held  <= 1'b1;
                  wdata_q <= axi.wdata;
                  wstrb_q <= axi.wstrb;
               end
               if (aw_held_next && w_held_next) begin
                  w_state      <= W_COMMIT;
                  axi.awready  <= 1'b0;
                  axi.wready   <= 1'b0;
                  reg_wr_pulse <= pulse_next;
               end else begin
                  // Each READY stays up only while its channel has nothing held
                  axi.awready <= !aw_held_next;
                  axi.wready  <= !w_held_next;
               end
            end

            W_COMMIT: begin
               for (int i = 0; i < STRB_W; i++) begin
                  if (wstrb_q[i]) begin
                     regs[aw_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                  end
               end
               reg_wr_pulse <= '0;
               aw_held      <= 1'b0;
               w_held       <= 1'b0;
               axi.bvalid   <= 1'b1;
               w_state      <= W_RESP;
            end

            W_RESP: begin
               if (axi.bready) begin
                  axi.bvalid  <= 1'b0;
                  axi.awready <= 1'b1;
                  axi.wready  <= 1'b1;
                  w_state     <= W_COLLECT;
               end
            end

            default: begin
               w_state <= W_COLLECT;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Read path: samples regs at the handshake edge, so a write committing
   // on that same edge is not yet visible.
   // ---------------------------------------------------------------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_state     <= R_IDLE;
         axi.arready <= 1'b0;
         axi.rvalid  <= 1'b0;
         axi.rdata   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (axi.arvalid && axi.arready) begin
                  axi.rdata   <= regs[axi.araddr[IDX_LSB +: 2]];
                  axi.rvalid  <= 1'b1;
                  axi.arready <= 1'b0;
                  r_state     <= R_DATA;
               end else begin
                  axi.arready <= 1'b1;
               end
            end

            R_DATA: begin
               if (axi.rready) begin
                  axi.rvalid  <= 1'b0;
                  axi.arready <= 1'b1;
                  r_state     <= R_IDLE;
               end
            end

            default: begin
               r_state <= R_IDLE;
            end
         endcase
      end
   end

   // Every index decodes to a register, so responses are always OKAY
   assign axi.bresp = 2'b00;
   assign axi.rresp = 2'b00;

   assign reg0_out = regs[0];
   assign reg1_out = regs[1];
   assign reg2_out = regs[2];
   assign reg3_out = regs[3];

   // Protection bits and the byte offset within a word carry no meaning here
   logic [2:0]                    unused_prot;
   logic [C_S_AXI_ADDR_WIDTH-1:0] unused_addr;
   assign unused_prot = axi.awprot ^ axi.arprot;
   assign unused_addr = axi.awaddr ^ axi.araddr;

endmodule

// File: doc/sobel_axil_regs.md
Name: sobel_axil_regs

Overview:
AXI4-Lite slave register file that responds to the sobel_filter control master and its BFM register tests. It holds four 32-bit read/write control registers and drives them to the filter datapath. It also emits a one-cycle update pulse per register. AW and W channels are accepted independently, and back-pressure on B and R is honoured.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; selects 4 word registers.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  synchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response; always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response; always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg0_out..reg3_out  out  32 each  current register contents
reg_wr_pulse  out  4  bit n high for 1 cycle when register n is written

Behaviour:
- Clocking and reset: one clock, S_AXI_ACLK. Reset S_AXI_ARESETN is synchronous and active-low.
- Reset values: all READY, VALID, RDATA, RESP, reg*_out and reg_wr_pulse outputs are 0. All held address and data state is cleared.
- READY outputs are registered. AWREADY and WREADY rise no earlier than 1 cycle after ARESETN=1.
- Address decode: word index = ADDR[3:2]. ADDR[1:0] are ignored. All 4 indices are valid, so the response is always OKAY.
- Write FSM states: W_COLLECT, W_COMMIT, W_RESP.
  - W_COLLECT:
    - AWREADY=1 while no address is held; WREADY=1 while no data is held.
    - AW and W may handshake in any order, or in the same cycle. The captured item is held and its READY drops the next cycle.
    - When both items are held, go to W_COMMIT.
  - W_COMMIT (1 cycle):
    - Byte lane i of the addressed register is updated iff WSTRB[i]=1.
    - reg_wr_pulse[n]=1 this cycle iff WSTRB!=0.
    - BVALID rises the next cycle. Go to W_RESP.
  - W_RESP:
    - BVALID held with AWREADY=WREADY=0 until BREADY=1. Then return to W_COLLECT with both ready.
  - Minimum write latency: 2 cycles from the last of AW/W handshake to BVALID.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On handshake, RDATA is loaded from the register contents as of that clock edge, i.e. before any write committing at the same edge. RVALID=1 the next cycle. Go to R_DATA.
  - R_DATA: ARREADY=0; RDATA and RVALID are held stable until RREADY=1. Then return to R_IDLE; the next AR is accepted 1 cycle later.
- Read and write paths are fully independent. A simultaneous read and write to the same register returns the old value.
- Reset asserted mid-transaction: at the next edge all FSMs go to idle, outstanding transactions are dropped without a response, and registers are zeroed.
- reg*_out update on the edge ending W_COMMIT. They are visible combinationally from flops, with no extra latency.

Test Plan:
- Basic write/readback: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to offsets 0x0, 0x4, 0x8, 0xC; read each back -> identical data, BRESP=RRESP=00, reg0_out..reg3_out match, reg_wr_pulse pulses 0001, 0010, 0100, 1000.
- Channel ordering: W presented 3 cycles before AW, then AW before W, then both together -> all commit correctly; exactly one BVALID per write.
- Byte strobes: reg1=0xABCD0001, then write 0x11223344 with WSTRB=0101 -> reg1 reads 0xAB220044. A write with WSTRB=0000 leaves the value unchanged and gives no pulse, but still returns BVALID.
- Back-pressure: hold BREADY=0 for 5 cycles -> BVALID stays 1, and AWREADY/WREADY stay 0. Hold RREADY=0 for 5 cycles -> RDATA is stable and ARREADY=0.
- Read/write collision: reg2=0xDEAD0011; AR and commit of 0x12345678 to reg2 on the same edge -> RDATA=0xDEAD0011. A subsequent read returns 0x12345678.
- Reset mid-operation: AW accepted, W pending, then ARESETN=0 for 1 cycle -> no BVALID; all regs read 0; the next full write completes normally.
